conv_layer_mc: RTL and testbench
================================

CONV_LAYER_MC -- requirements
Module: conv_layer_mc

Interface
REQ-001 Parameter KERNEL, default 3: kernel side; the window holds KERNEL*KERNEL taps.
REQ-002 Parameter E, default 3: per-window sum growth bits; the sum width is N+M+E+1.
REQ-003 Parameter N, default 4: unsigned data width per tap.
REQ-004 Parameter M, default 4: two's-complement weight width per tap.
REQ-005 Parameter CH, default 2: input channels accumulated per output; legal range 1..256.
REQ-006 Parameter CE, default 1: channel growth bits, at least ceil(log2(CH)) and at least 1.
REQ-007 Derived ACC_W = N+M+E+CE+1: signed output width.
REQ-008 clk  in  1  single clock; all flops rise-edge triggered.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 clr  in  1  synchronous flush of the channel counter and the pipeline.
REQ-011 data2conv  in  KERNEL*KERNEL*N  window taps; tap i is at bits [i*N +: N].
REQ-012 w  in  KERNEL*KERNEL*M  weights; weight i is at bits [i*M +: M].
REQ-013 en_in  in  1  the current data2conv/w pair is one channel beat.
REQ-014 d_out  out  ACC_W  signed multichannel convolution result.
REQ-015 en_out  out  1  one-cycle strobe marking d_out valid.
REQ-016 ch_idx  out  CE  channel index the next en_in beat will carry.

Function
REQ-017 Each beat SHALL compute S = sum over i of data[i] (zero-extended) * w[i] (signed), exact in N+M+E+1 bits.
REQ-018 Pipeline SHALL be 3 registered stages: products; adder-tree sum; channel accumulator/output.
REQ-019 The beat accepted at edge t SHALL register products at t, the tree sum at t+1, and d_out with en_out=1 at t+2 when it is the last channel.
REQ-020 Each beat SHALL carry first/last flags from ch_idx through the pipeline: first is ch_idx==0, last is ch_idx==CH-1.
REQ-021 Accumulator SHALL load S on a first beat and add S otherwise, with no bubble between back-to-back windows.
REQ-022 ch_idx SHALL increment on each accepted beat and wrap from CH-1 to 0; with CH=1 every beat is first and last.
REQ-023 Gaps in en_in are allowed at any point; a partial window SHALL hold its state indefinitely.
REQ-024 There is no backpressure; a beat is accepted on every cycle en_in=1.
REQ-025 en_out SHALL be 1 for exactly one cycle per completed window; d_out SHALL hold its value until the next en_out.
REQ-026 Accumulation SHALL be signed, sign-extending S to ACC_W; no overflow is possible within parameter limits.
REQ-027 clr=1 SHALL zero ch_idx and drop all in-flight beats, including a beat presented in the same cycle with en_in=1 (clr wins).
REQ-028 d_out SHALL keep its last value during and after clr; en_out SHALL be 0 on the cycle after clr.

Reset
REQ-029 rst=1 SHALL asynchronously clear ch_idx, all pipeline valid/flag bits, the accumulator, d_out (0) and en_out (0).
REQ-030 Reset asserted mid-window SHALL discard the partial window; the first beat after release SHALL be channel 0.

Configuration
REQ-031 Macro CONV_LAYER_MC_RELU_EN defined: d_out SHALL be forced to 0 when the final accumulated value is negative; en_out timing is unchanged.
REQ-032 Macro CONV_LAYER_MC_RELU_EN undefined: d_out SHALL be the raw signed accumulation.

Verification (KERNEL=3, N=4, M=4, E=3, CH=2, CE=1, ACC_W=13)
REQ-033 Two consecutive beats with all taps 1 and all weights 1 -> en_out one cycle at edge t+2 after the second beat, d_out=18.
REQ-034 Two beats with taps 15 and weights 4'h8 (-8) -> d_out=-2160 (13'h1790); with RELU_EN d_out=0.
REQ-035 Windows back-to-back (4 beats, weights 1, taps 1 then 2) -> en_out after beat 2 with 18, after beat 4 with 36, no lost cycle.
REQ-036 Beat 1, 5 idle cycles, beat 2 -> single en_out, correct sum; ch_idx stays 1 throughout the gap.
REQ-037 clr asserted together with beat 2 -> no en_out; a following 2-beat window yields only its own sum.
REQ-038 rst pulsed between beats 1 and 2 -> ch_idx=0 and en_out=0; the next 2 beats produce a correct fresh sum.

Source files
------------

// File: rtl/conv_layer_mc.sv
// rtl/conv_layer_mc.sv - multichannel KxK convolution: products, adder tree, channel accumulator.
// Optional macro CONV_LAYER_MC_RELU_EN clamps negative window results to zero.
module conv_layer_mc #(
    parameter int KERNEL = 3,
    parameter int E      = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int CH     = 2,
    parameter int CE     = 1,
    localparam int ACC_W = N + M + E + CE + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [KERNEL*KERNEL*N-1:0] data2conv,
    input  logic [KERNEL*KERNEL*M-1:0] w,
    input  logic                       en_in,
    output logic [ACC_W-1:0]           d_out,
    output logic                       en_out,
    output logic [CE-1:0]              ch_idx
);

    localparam int KK    = KERNEL * KERNEL;
    localparam int P_W   = N + M + 1;
    localparam int SUM_W = N + M + E + 1;
    localparam logic [CE-1:0] LAST_CH = CE'(CH - 1);

    logic accept;
    logic first_c;
    logic last_c;

    logic signed [P_W-1:0] tap_x  [KK];
    logic signed [P_W-1:0] wt_x   [KK];
    logic signed [P_W-1:0] prod_c [KK];
    logic signed [P_W-1:0] prod_q [KK];
    logic                  s1_valid, s1_first, s1_last;

    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] sum_q;
    logic                    s2_valid, s2_first, s2_last;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] result_c;

    // clr overrides a simultaneous beat
    assign accept  = en_in & ~clr;
    assign first_c = (ch_idx == '0);
    assign last_c  = (ch_idx == LAST_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx <= '0;
        end else if (clr) begin
            ch_idx <= '0;
        end else if (en_in) begin
            ch_idx <= last_c ? '0 : ch_idx + CE'(1);
        end
    end

    // Taps are unsigned: a zero MSB makes them safe signed operands.
    always_comb begin
        for (int i = 0; i < KK; i++) begin
            tap_x[i]  = P_W'($signed({1'b0, data2conv[i*N +: N]}));
            wt_x[i]   = P_W'($signed(w[i*M +: M]));
            prod_c[i] = tap_x[i] * wt_x[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= prod_c[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_first <= first_c;
            s1_last  <= last_c;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < KK; i++) begin
            sum_c = sum_c + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            sum_q <= sum_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid & ~clr;
            s2_first <= s1_first;
            s2_last  <= s1_last;
        end
    end

    // A first beat reloads, so back-to-back windows need no clearing bubble.
    assign acc_next = s2_first ? ACC_W'(sum_q) : acc + ACC_W'(sum_q);

`ifdef CONV_LAYER_MC_RELU_EN
    assign result_c = acc_next[ACC_W-1] ? '0 : acc_next;
`else
    assign result_c = acc_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            d_out  <= '0;
            en_out <= 1'b0;
        end else begin
            en_out <= 1'b0;
            if (s2_valid && !clr) begin
                acc <= acc_next;
                if (s2_last) begin
                    d_out  <= result_c;
                    en_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_mc.sv
// tb/tb_conv_layer_mc.sv - scoreboard bench for conv_layer_mc (KERNEL=3, N=4, M=4, E=3, CH=2).
module tb_conv_layer_mc;

    localparam int CH    = 2;
    localparam int ACC_W = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [35:0] data2conv;
    logic [35:0] w;
    logic        en_in;
    logic [12:0] d_out;
    logic        en_out;
    logic [0:0]  ch_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tb_ch = 0;
    int acc_model = 0;
    logic signed [12:0] exp_q[$];
    int pulse_cyc[$];
    logic signed [12:0] mon_exp;

    conv_layer_mc #(.KERNEL(3), .E(3), .N(4), .M(4), .CH(2), .CE(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .data2conv(data2conv), .w(w),
        .en_in(en_in), .d_out(d_out), .en_out(en_out), .ch_idx(ch_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && en_out) begin
            pulse_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_en_out: d_out=%0d, required no output", $signed(d_out));
            end else begin
                mon_exp = exp_q.pop_front();
                if (d_out !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_d_out: got %0d, required %0d", $signed(d_out), mon_exp);
                end
            end
        end
    end

    function automatic logic [35:0] rep(input logic [3:0] v);
        logic [35:0] r;
        for (int i = 0; i < 9; i++) r[i*4 +: 4] = v;
        return r;
    endfunction

    function automatic int beat_sum(input logic [35:0] d, input logic [35:0] wv);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(d[i*4 +: 4]) * int'($signed(wv[i*4 +: 4]));
        return s;
    endfunction

    function automatic logic signed [12:0] out_model(input int a);
        int r;
        r = a;
`ifdef CONV_LAYER_MC_RELU_EN
        if (r < 0) r = 0;
`endif
        return 13'(r);
    endfunction

    task automatic model_beat(input logic [35:0] d, input logic [35:0] wv);
        int s;
        s = beat_sum(d, wv);
        acc_model = (tb_ch == 0) ? s : acc_model + s;
        if (tb_ch == CH - 1) begin
            exp_q.push_back(out_model(acc_model));
            tb_ch = 0;
        end else begin
            tb_ch++;
        end
    endtask

    task automatic drive_beat(input logic [35:0] d, input logic [35:0] wv);
        data2conv = d;
        w = wv;
        en_in = 1'b1;
        model_beat(d, wv);
        @(posedge clk);
        #1;
        en_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clr = 1'b0;
        en_in = 1'b0;
        data2conv = '0;
        w = '0;
        idle(2);
        checks++;
        if (d_out !== 13'd0) begin errors++; $display("FAIL reset_d_out: got %0d, required 0", d_out); end
        checks++;
        if (en_out !== 1'b0) begin errors++; $display("FAIL reset_en_out: got %0b, required 0", en_out); end
        checks++;
        if (ch_idx !== 1'b0) begin errors++; $display("FAIL reset_ch_idx: got %0d, required 0", ch_idx); end
        rst = 1'b0;
        tb_ch = 0;
        idle(1);
    endtask

    task automatic test_basic;
        drive_beat(rep(4'd1), rep(4'd1));
        checks++;
        if (ch_idx !== 1'b1) begin errors++; $display("FAIL basic_ch_idx_after_beat1: got %0d, required 1", ch_idx); end
        drive_beat(rep(4'd1), rep(4'd1));
        checks++;
        if (ch_idx !== 1'b0 || en_out !== 1'b0) begin
            errors++; $display("FAIL basic_edge_t: ch_idx=%0d en_out=%0b, required 0 0", ch_idx, en_out);
        end
        idle(1);
        checks++;
        if (en_out !== 1'b0) begin errors++; $display("FAIL basic_edge_t1_en_out: got %0b, required 0", en_out); end
        idle(1);
        checks++;
        if (en_out !== 1'b1 || d_out !== 13'd18) begin
            errors++; $display("FAIL basic_edge_t2: en_out=%0b d_out=%0d, required 1 18", en_out, $signed(d_out));
        end
        idle(1);
        checks++;
        if (en_out !== 1'b0 || d_out !== 13'd18) begin
            errors++; $display("FAIL basic_hold: en_out=%0b d_out=%0d, required 0 18", en_out, $signed(d_out));
        end
    endtask

    task automatic test_negative;
        logic [12:0] req;
`ifdef CONV_LAYER_MC_RELU_EN
        req = 13'd0;
`else
        req = 13'h1790;
`endif
        drive_beat(rep(4'd15), rep(4'h8));
        drive_beat(rep(4'd15), rep(4'h8));
        idle(3);
        checks++;
        if (d_out !== req) begin errors++; $display("FAIL negative_d_out: got %0h, required %0h", d_out, req); end
    endtask

    task automatic test_back_to_back;
        pulse_cyc.delete();
        drive_beat(rep(4'd1), rep(4'd1));
        drive_beat(rep(4'd1), rep(4'd1));
        drive_beat(rep(4'd2), rep(4'd1));
        drive_beat(rep(4'd2), rep(4'd1));
        idle(4);
        checks++;
        if (pulse_cyc.size() != 2) begin
            errors++; $display("FAIL b2b_pulse_count: got %0d, required 2", pulse_cyc.size());
        end else begin
            checks++;
            if (pulse_cyc[1] - pulse_cyc[0] != 2) begin
                errors++; $display("FAIL b2b_spacing: got %0d cycles, required 2", pulse_cyc[1] - pulse_cyc[0]);
            end
        end
        checks++;
        if (d_out !== 13'd36) begin errors++; $display("FAIL b2b_last_d_out: got %0d, required 36", $signed(d_out)); end
    endtask

    task automatic test_gap;
        int bad;
        bad = 0;
        pulse_cyc.delete();
        drive_beat(rep(4'd5), rep(4'd1));
        repeat (5) begin
            idle(1);
            if (ch_idx !== 1'b1 || en_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL gap_hold: %0d bad cycles, required 0", bad); end
        drive_beat(rep(4'd2), rep(4'd1));
        idle(4);
        checks++;
        if (pulse_cyc.size() != 1 || d_out !== 13'd63) begin
            errors++; $display("FAIL gap_result: pulses=%0d d_out=%0d, required 1 63", pulse_cyc.size(), $signed(d_out));
        end
    endtask

    task automatic test_clr;
        int bad;
        pulse_cyc.delete();
        drive_beat(rep(4'd4), rep(4'd1));
        data2conv = rep(4'd7);
        w = rep(4'd1);
        en_in = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        en_in = 1'b0;
        clr = 1'b0;
        tb_ch = 0;
        checks++;
        if (ch_idx !== 1'b0 || en_out !== 1'b0) begin
            errors++; $display("FAIL clr_state: ch_idx=%0d en_out=%0b, required 0 0", ch_idx, en_out);
        end
        idle(4);
        checks++;
        if (pulse_cyc.size() != 0) begin errors++; $display("FAIL clr_no_output: got %0d pulses, required 0", pulse_cyc.size()); end
        drive_beat(rep(4'd2), rep(4'd3));
        drive_beat(rep(4'd2), rep(4'd3));
        idle(4);
        checks++;
        if (pulse_cyc.size() != 1 || d_out !== 13'd108) begin
            errors++; $display("FAIL clr_fresh_window: pulses=%0d d_out=%0d, required 1 108", pulse_cyc.size(), $signed(d_out));
        end
        // completed window flushed by clr while still in the pipeline
        drive_beat(rep(4'd1), rep(4'd1));
        drive_beat(rep(4'd1), rep(4'd1));
        void'(exp_q.pop_back());
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bad = 0;
        repeat (4) begin
            if (en_out !== 1'b0 || d_out !== 13'd108) bad++;
            idle(1);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clr_flush_inflight: %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_reset_mid;
        drive_beat(rep(4'd9), rep(4'd1));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ch_idx !== 1'b0 || en_out !== 1'b0 || d_out !== 13'd0) begin
            errors++; $display("FAIL reset_mid: ch_idx=%0d en_out=%0b d_out=%0d, required 0 0 0", ch_idx, en_out, d_out);
        end
        tb_ch = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_beat(rep(4'd3), rep(4'hF));
        drive_beat(rep(4'd3), rep(4'hF));
        idle(4);
        checks++;
        if (d_out !== out_model(-54)) begin
            errors++; $display("FAIL reset_mid_fresh: got %0d, required %0d", $signed(d_out), out_model(-54));
        end
    endtask

    task automatic test_random;
        logic [35:0] d;
        logic [35:0] wv;
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 9; i++) begin
                d[i*4 +: 4]  = 4'($urandom_range(0, 15));
                wv[i*4 +: 4] = 4'($urandom_range(0, 15));
            end
            drive_beat(d, wv);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_gap();
        test_clr();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
